i2c_slave_regfile: RTL and testbench
====================================

Name: i2c_slave_regfile

Overview:
- Parametrised I2C slave with an internal register file, for decoder and peripheral simulation models in the video-input bench.
- Successor to the ACK-only I2C stub: it matches the device address and decodes write and read transactions.
- Supports a register pointer with auto-increment, repeated start, and read-back.
- Exposes a write strobe and a combinational register read port, so the enclosing model can react to configuration writes.

Parameters:
- DEV_ADDR, 7'h20: 7-bit slave address. 7'h20 corresponds to 8'h40 write / 8'h41 read.
- REG_AW, 8: register address width. The register count is 2**REG_AW.
- AUTO_INC, 1: 1 = pointer increments after each data byte; 0 = pointer holds.

Ports:
- nRESET  in  1  asynchronous, active-low reset
- clk  in  1  oversampling clock; must be at least 8x the SCL rate
- scl_i  in  1  I2C clock from the bus
- sda_i  in  1  I2C data from the bus
- sda_oe  out  1  1 = pull SDA low; the wrapper models this as open drain
- wr_stb  out  1  one-clk pulse on each committed register write
- wr_addr  out  REG_AW  address of the committed write
- wr_data  out  8  data of the committed write
- rd_addr  in  REG_AW  side read port address
- rd_data  out  8  combinational read of regs[rd_addr]
- busy  out  1  high between a matched address and the next STOP/START

Behaviour:
- Reset: all regs 8'h00; pointer 0; sda_oe 0; wr_stb 0; busy 0; state IDLE. Synchronizer flops reset to 1.
- Input sampling: scl_i and sda_i pass through a 2-flop synchronizer plus one delayed copy.
  - rise = scl & ~scl_d; fall = ~scl & scl_d.
  - START = scl & scl_d & sda_d & ~sda; STOP = scl & scl_d & ~sda_d & sda.
- START or STOP in any state, mid-byte included:
  - Bit counter cleared; sda_oe released the same clk.
  - Any partially shifted byte is discarded with no write.
  - START -> ADDR. STOP -> IDLE; busy 0.
- Data sampling: bits are sampled MSB first on rise. The bit counter counts 0..7.
- sda_oe changes only on fall, so SDA is always stable while SCL is high.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. On the fall after bit 7:
    - if byte[7:1]==DEV_ADDR, go to ACK_A, assert sda_oe, busy 1, latch R/W;
    - otherwise go to IGNORE with no ACK.
  - ACK_A: on the next fall, release sda_oe.
    - W -> PTR.
    - R -> RD, loading shift = regs[ptr] and driving its MSB: sda_oe = ~bit7.
  - PTR: shift 8 bits into the pointer (low REG_AW bits used). ACK -> WR.
  - WR: shift 8 bits. At the fall ending bit 7, pulse wr_stb for 1 clk with wr_addr = ptr and wr_data = byte.
    - regs[ptr] updates on the same edge.
    - ptr increments if AUTO_INC.
    - ACK, then stay in WR.
  - RD: drive sda_oe = ~shift[7-bitcnt], updated at each fall. After 8 bits, release sda_oe and go to MACK.
  - MACK: sample SDA on rise.
    - 0 (ACK): increment ptr if AUTO_INC; reload shift from the new ptr at the fall; return to RD.
    - 1 (NACK): go to IGNORE.
  - IGNORE: hold sda_oe 0 until STOP or START.
- Pointer wrap: 2**REG_AW-1 increments to 0.
- Pointer persistence: the pointer keeps its value across STOP, so a later read without a pointer phase reads from the current ptr.
- Repeated start after PTR/ACK keeps the pointer, enabling the standard write-pointer-then-read sequence.
- Conflicts: wr_stb never coincides with a START/STOP-detect clk; a START/STOP wins and the write is dropped.
- Reset mid-transaction: all state returns to reset values immediately. sda_oe is released asynchronously.

Test Plan:
- Write burst: START, 40, 10, AA, 55, STOP -> ACK on all 4 bytes; wr_stb twice (10<-AA, 11<-55); rd_data at rd_addr 8'h11 = 55; busy low after STOP.
- Address mismatch: START, 42, 00, STOP -> no ACK on any byte; sda_oe never asserted; wr_stb never pulses; busy stays 0.
- Repeated-start read: preload 10=AA, 11=55. Send START, 40, 10, Sr, 41, read with ACK then NACK, STOP -> bytes AA, 55 returned; SDA stable while SCL high.
- Wrap: REG_AW=8; write FF<-12, then next byte 34 -> regs[FF]=12, regs[00]=34.
- Abort: STOP after 4 data bits of a WR byte -> no wr_stb; register unchanged; state IDLE. nRESET low mid-read -> sda_oe 0 within the same clk; all regs 00.
- AUTO_INC=0: write 20<-01, 02 -> regs[20]=02; wr_stb fires twice, both times with wr_addr 20.

Source files
------------

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: I2C slave with an internal register file.
// Used as a decoder/peripheral model in the video-input bench.
module i2c_slave_regfile #(
    parameter logic [6:0] DEV_ADDR = 7'h20,
    parameter int         REG_AW   = 8,
    parameter bit         AUTO_INC = 1'b1
) (
    input  logic              nRESET,
    input  logic              clk,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic              wr_stb,
    output logic [REG_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic [REG_AW-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              busy
);
    localparam int NREG = 1 << REG_AW;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ACK_A,
        PTR,
        ACK_D,
        WR,
        RD,
        MACK,
        IGNORE
    } state_t;

    state_t state, state_n;

    logic scl_s1, scl_s, scl_d;
    logic sda_s1, sda_s, sda_d;
    logic rise, fall, start, stop;
    logic done, match;

    logic [3:0]        bitcnt;
    logic [7:0]        shreg;
    logic [7:0]        txsh;
    logic              rw;
    logic              mnack;
    logic [REG_AW-1:0] ptr;
    logic [REG_AW-1:0] ptr_inc;
    logic [7:0]        regs [NREG];

    // Two-flop synchronizer plus one delayed copy for edge detection
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            scl_s1 <= 1'b1;
            scl_s  <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s  <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= scl_i;
            scl_s  <= scl_s1;
            scl_d  <= scl_s;
            sda_s1 <= sda_i;
            sda_s  <= sda_s1;
            sda_d  <= sda_s;
        end
    end

    assign rise  = scl_s & ~scl_d;
    assign fall  = ~scl_s & scl_d;
    assign start = scl_s & scl_d & sda_d & ~sda_s;
    assign stop  = scl_s & scl_d & ~sda_d & sda_s;

    // bitcnt reaches 8 once all eight bits of a byte have been sampled
    assign done    = (bitcnt == 4'd8);
    assign match   = (shreg[7:1] == DEV_ADDR);
    assign ptr_inc = AUTO_INC ? ptr + 1'b1 : ptr;
    assign rd_data = regs[rd_addr];

    // State register
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; bus conditions override everything
    always_comb begin
        state_n = state;
        if (start) begin
            state_n = ADDR;
        end else if (stop) begin
            state_n = IDLE;
        end else if (fall) begin
            unique case (state)
                ADDR:    if (done) state_n = match ? ACK_A : IGNORE;
                ACK_A:   state_n = rw ? RD : PTR;
                PTR:     if (done) state_n = ACK_D;
                WR:      if (done) state_n = ACK_D;
                ACK_D:   state_n = WR;
                RD:      if (done) state_n = MACK;
                MACK:    state_n = mnack ? IGNORE : RD;
                default: state_n = state;
            endcase
        end
    end

    // Shifting, pointer, register file and SDA drive
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            bitcnt  <= 4'd0;
            shreg   <= 8'h00;
            txsh    <= 8'h00;
            rw      <= 1'b0;
            mnack   <= 1'b1;
            ptr     <= '0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
            wr_data <= 8'h00;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            wr_stb <= 1'b0;
            if (start || stop) begin
                bitcnt <= 4'd0;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (rise) begin
                unique case (state)
                    ADDR, PTR, WR: begin
                        if (!done) begin
                            shreg  <= {shreg[6:0], sda_s};
                            bitcnt <= bitcnt + 4'd1;
                        end
                    end
                    RD: begin
                        if (!done) bitcnt <= bitcnt + 4'd1;
                    end
                    MACK:    mnack <= sda_s;
                    default: ;
                endcase
            end else if (fall) begin
                unique case (state)
                    ADDR: begin
                        if (done) begin
                            bitcnt <= 4'd0;
                            if (match) begin
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                                rw     <= shreg[0];
                            end
                        end
                    end
                    ACK_A: begin
                        sda_oe <= rw ? ~regs[ptr][7] : 1'b0;
                        if (rw) txsh <= regs[ptr];
                    end
                    PTR: begin
                        if (done) begin
                            bitcnt <= 4'd0;
                            ptr    <= REG_AW'(shreg);
                            sda_oe <= 1'b1;
                        end
                    end
                    WR: begin
                        if (done) begin
                            bitcnt    <= 4'd0;
                            wr_stb    <= 1'b1;
                            wr_addr   <= ptr;
                            wr_data   <= shreg;
                            regs[ptr] <= shreg;
                            ptr       <= ptr_inc;
                            sda_oe    <= 1'b1;
                        end
                    end
                    ACK_D: sda_oe <= 1'b0;
                    RD: begin
                        if (done) begin
                            bitcnt <= 4'd0;
                            sda_oe <= 1'b0;
                        end else if (bitcnt != 4'd0) begin
                            sda_oe <= ~txsh[~bitcnt[2:0]];
                        end
                    end
                    MACK: begin
                        if (!mnack) begin
                            ptr    <= ptr_inc;
                            txsh   <= regs[ptr_inc];
                            sda_oe <= ~regs[ptr_inc][7];
                        end
                    end
                    default: sda_oe <= 1'b0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb_i2c_slave_regfile: bit-banged I2C master against two slaves
// (auto-increment and fixed-pointer) with a register-file model.
module tb_i2c_slave_regfile;
    localparam int Q = 6;

    logic clk    = 1'b0;
    logic nRESET = 1'b0;
    logic scl    = 1'b1;
    logic sda_m  = 1'b1;
    logic sda_bus;

    logic       oe1, stb1, busy1;
    logic [7:0] wa1, wd1, ra1, rd1;
    logic       oe2, stb2, busy2;
    logic [7:0] wa2, wd2, ra2, rd2;

    assign sda_bus = sda_m & ~oe1 & ~oe2;

    always #5 clk = ~clk;

    i2c_slave_regfile dut (
        .nRESET (nRESET),
        .clk    (clk),
        .scl_i  (scl),
        .sda_i  (sda_bus),
        .sda_oe (oe1),
        .wr_stb (stb1),
        .wr_addr(wa1),
        .wr_data(wd1),
        .rd_addr(ra1),
        .rd_data(rd1),
        .busy   (busy1)
    );

    i2c_slave_regfile #(
        .DEV_ADDR(7'h50),
        .AUTO_INC(1'b0)
    ) dut2 (
        .nRESET (nRESET),
        .clk    (clk),
        .scl_i  (scl),
        .sda_i  (sda_bus),
        .sda_oe (oe2),
        .wr_stb (stb2),
        .wr_addr(wa2),
        .wr_data(wd2),
        .rd_addr(ra2),
        .rd_data(rd2),
        .busy   (busy2)
    );

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } stb_t;

    typedef struct {
        logic [7:0] dev;
        logic [7:0] ptr;
        logic [7:0] d0;
        logic [7:0] d1;
        int         nd;
        bit         ack;
        logic [7:0] ca0;
        logic [7:0] cv0;
        logic [7:0] ca1;
        logic [7:0] cv1;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    stb_t stbq1[$];
    stb_t stbq2[$];
    int   oe1_hi   = 0;
    int   busy1_hi = 0;
    int   unstable = 0;
    logic scl_q    = 1'b1;
    logic oe1_q    = 1'b0;

    logic [7:0] mregs [256];
    logic [7:0] mptr;
    logic [7:0] wbuf  [4];

    // Observe strobes, SDA activity and SDA stability while SCL is high
    always @(negedge clk) begin
        if (stb1) stbq1.push_back({wa1, wd1});
        if (stb2) stbq2.push_back({wa2, wd2});
        if (oe1) oe1_hi++;
        if (busy1) busy1_hi++;
        if (scl && scl_q && (oe1 != oe1_q)) unstable++;
        scl_q = scl;
        oe1_q = oe1;
    end

    initial begin
        #800000;
        $display("FAIL timeout: run did not complete");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mregs[i] = 8'h00;
        mptr = 8'h00;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        sda_m = 1'b0;
        tick(Q);
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        sda_m = 1'b1;
        tick(Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;
        tick(Q);
        scl = 1'b1;
        tick(2 * Q);
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        ack = !sda_bus;
        tick(Q);
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic recv_byte(input bit ack_it, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1;
            tick(Q);
            scl = 1'b1;
            tick(Q);
            b[i] = sda_bus;
            tick(Q);
            scl = 1'b0;
            tick(Q);
        end
        send_bit(ack_it ? 1'b0 : 1'b1);
    endtask

    task automatic wr_tx(input logic [7:0] dev, input logic [7:0] p,
                         input int n, output bit all_ack,
                         output bit any_ack);
        bit   a;
        bit   hit;
        int   s;
        stb_t got;
        hit     = (dev == 8'h40);
        s       = stbq1.size();
        all_ack = 1'b1;
        any_ack = 1'b0;
        i2c_start();
        send_byte(dev, a);
        all_ack &= a;
        any_ack |= a;
        send_byte(p, a);
        all_ack &= a;
        any_ack |= a;
        for (int i = 0; i < n; i++) begin
            send_byte(wbuf[i], a);
            all_ack &= a;
            any_ack |= a;
        end
        i2c_stop();
        tick(2);
        check("wr stb count", stbq1.size() - s, hit ? n : 0);
        if (hit) begin
            mptr = p;
            for (int i = 0; i < n; i++) begin
                if (s + i < stbq1.size()) got = stbq1[s+i];
                else got = 16'hxxxx;
                check("wr stb addr/data", got, {mptr, wbuf[i]});
                mregs[mptr] = wbuf[i];
                mptr++;
            end
        end
        check("busy after stop", busy1, 1'b0);
    endtask

    task automatic rd_tx(input bit set_ptr, input logic [7:0] p,
                         input int n);
        bit         a;
        logic [7:0] b;
        i2c_start();
        if (set_ptr) begin
            send_byte(8'h40, a);
            check("rd wr-addr ack", a, 1'b1);
            send_byte(p, a);
            check("rd ptr ack", a, 1'b1);
            mptr = p;
            i2c_start();
        end
        send_byte(8'h41, a);
        check("rd addr ack", a, 1'b1);
        for (int i = 0; i < n; i++) begin
            recv_byte(i < n - 1, b);
            check("rd data", b, mregs[mptr]);
            if (i < n - 1) mptr++;
        end
        i2c_stop();
        tick(2);
        check("busy after read", busy1, 1'b0);
    endtask

    initial begin
        vec_t       vt [4];
        bit         aa, an, a;
        int         s, u0;
        logic [7:0] b;
        stb_t       got;

        vt[0] = '{8'h40, 8'h10, 8'hAA, 8'h55, 2, 1'b1,
                  8'h10, 8'hAA, 8'h11, 8'h55};
        vt[1] = '{8'h42, 8'h00, 8'h00, 8'h00, 0, 1'b0,
                  8'h00, 8'h00, 8'h11, 8'h55};
        vt[2] = '{8'h40, 8'hFF, 8'h12, 8'h34, 2, 1'b1,
                  8'hFF, 8'h12, 8'h00, 8'h34};
        vt[3] = '{8'h40, 8'h7E, 8'hC3, 8'h00, 1, 1'b1,
                  8'h7E, 8'hC3, 8'h7F, 8'h00};

        ra1 = 8'h00;
        ra2 = 8'h00;
        model_reset();

        tick(3);
        check("reset sda_oe", oe1, 1'b0);
        check("reset wr_stb", stb1, 1'b0);
        check("reset busy", busy1, 1'b0);
        ra1 = 8'hFF;
        #1 check("reset reg FF", rd1, 8'h00);
        nRESET = 1'b1;
        tick(4);

        // Table of write transactions: burst, mismatch, wrap, single
        for (int k = 0; k < 4; k++) begin
            int o0, b0;
            wbuf[0] = vt[k].d0;
            wbuf[1] = vt[k].d1;
            o0 = oe1_hi;
            b0 = busy1_hi;
            wr_tx(vt[k].dev, vt[k].ptr, vt[k].nd, aa, an);
            check("vec any ack", an, vt[k].ack);
            if (vt[k].ack) check("vec all ack", aa, 1'b1);
            check("vec busy seen", busy1_hi != b0, vt[k].ack);
            check("vec sda_oe seen", oe1_hi != o0, vt[k].ack);
            ra1 = vt[k].ca0;
            #1 check("vec reg a", rd1, vt[k].cv0);
            ra1 = vt[k].ca1;
            #1 check("vec reg b", rd1, vt[k].cv1);
        end

        // Pointer write then repeated-start read of AA, 55
        u0 = unstable;
        rd_tx(1'b1, 8'h10, 2);
        check("sda stable while scl high", unstable - u0, 0);

        // Pointer persists: read without pointer phase
        rd_tx(1'b0, 8'h00, 1);

        // STOP after four data bits drops the byte
        wbuf[0] = 8'h5A;
        wr_tx(8'h40, 8'h30, 1, aa, an);
        i2c_start();
        send_byte(8'h40, a);
        send_byte(8'h30, a);
        mptr = 8'h30;
        s = stbq1.size();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        i2c_stop();
        tick(4);
        check("abort stb count", stbq1.size() - s, 0);
        check("abort busy", busy1, 1'b0);
        check("abort sda_oe", oe1, 1'b0);
        ra1 = 8'h30;
        #1 check("abort reg kept", rd1, 8'h5A);
        rd_tx(1'b0, 8'h00, 1);

        // Fixed-pointer device: both writes land on 20
        s = stbq2.size();
        u0 = busy1_hi;
        i2c_start();
        send_byte(8'hA0, a);
        check("ninc addr ack", a, 1'b1);
        send_byte(8'h20, a);
        check("ninc ptr ack", a, 1'b1);
        send_byte(8'h01, a);
        check("ninc d0 ack", a, 1'b1);
        send_byte(8'h02, a);
        check("ninc d1 ack", a, 1'b1);
        i2c_stop();
        tick(2);
        check("ninc stb count", stbq2.size() - s, 2);
        got = (s < stbq2.size()) ? stbq2[s] : 16'hxxxx;
        check("ninc stb 0", got, 16'h2001);
        got = (s + 1 < stbq2.size()) ? stbq2[s+1] : 16'hxxxx;
        check("ninc stb 1", got, 16'h2002);
        ra2 = 8'h20;
        #1 check("ninc reg 20", rd2, 8'h02);
        ra2 = 8'h21;
        #1 check("ninc reg 21", rd2, 8'h00);
        check("other dev stays idle", busy1_hi - u0, 0);

        // Reset asserted while the slave drives a 0 during a read
        i2c_start();
        send_byte(8'h40, a);
        send_byte(8'h10, a);
        i2c_start();
        send_byte(8'h41, a);
        send_bit(1'b1);
        tick(1);
        check("mid-read sda_oe driven", oe1, 1'b1);
        @(negedge clk);
        #2 nRESET = 1'b0;
        #1 check("reset releases sda_oe", oe1, 1'b0);
        check("reset busy mid-read", busy1, 1'b0);
        ra1 = 8'h10;
        #1 check("reset clears reg 10", rd1, 8'h00);
        ra1 = 8'hFF;
        #1 check("reset clears reg FF", rd1, 8'h00);
        ra2 = 8'h20;
        #1 check("reset clears dev2 reg", rd2, 8'h00);
        scl   = 1'b1;
        sda_m = 1'b1;
        tick(3);
        nRESET = 1'b1;
        model_reset();
        tick(4);

        // Random writes and reads against the model
        for (int it = 0; it < 16; it++) begin
            if (it < 5 || $urandom_range(0, 1) == 1) begin
                int n;
                logic [7:0] p;
                p = 8'($urandom);
                n = $urandom_range(1, 4);
                for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
                wr_tx(8'h40, p, n, aa, an);
                check("rand wr ack", aa, 1'b1);
            end else begin
                rd_tx($urandom_range(0, 1) == 1, 8'($urandom),
                      $urandom_range(1, 3));
            end
            ra1 = 8'($urandom);
            #1 check("rand rd_data", rd1, mregs[ra1]);
        end
        check("sda stable overall", unstable, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
